// File: rtl/hazard_forward_scoreboard.sv
// Load-use stall and EX bypass control driven by a shift-register scoreboard of in-flight
// instructions from EX down to the last forwardable stage.
module hazard_forward_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic              stall_count_clr,
  output logic [SW-1:0]     fwd_a,
  output logic [SW-1:0]     fwd_b,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ctrl_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
  } slot_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot0_d;
  logic [CNT_W-1:0] stall_count_q;
  logic             haz_a, haz_b;
  logic             a_early, b_early;

  function automatic logic is_producer(slot_t s, logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.dst != '0) && (s.dst == r);
  endfunction

  // Walk oldest to youngest so the youngest producer is the last assignment.
  always_comb begin
    fwd_a   = '0;
    fwd_b   = '0;
    a_early = 1'b0;
    b_early = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 1; i--) begin
      if (slot_q[0].valid && slot_q[0].rs_used && is_producer(slot_q[i], slot_q[0].rs)) begin
        fwd_a   = SW'(i);
        a_early = slot_q[i].memread && (i < int'(LOAD_READY));
      end
      if (slot_q[0].valid && slot_q[0].rt_used && is_producer(slot_q[i], slot_q[0].rt)) begin
        fwd_b   = SW'(i);
        b_early = slot_q[i].memread && (i < int'(LOAD_READY));
      end
    end
  end

  // A younger non-load producer overrides an older load on the same register.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
      if (is_producer(slot_q[j], id_rs)) haz_a = slot_q[j].memread && (j + 1 < int'(LOAD_READY));
      if (is_producer(slot_q[j], id_rt)) haz_b = slot_q[j].memread && (j + 1 < int'(LOAD_READY));
    end
  end

  always_comb begin
    stall       = id_valid && ((id_rs_used && haz_a) || (id_rt_used && haz_b)) && !flush;
    pc_write    = !stall;
    if_id_write = !stall;
    ctrl_bubble = stall || flush;
    stall_count = stall_count_q;
  end

  always_comb begin
    slot0_d.valid    = id_valid && !ctrl_bubble;
    slot0_d.dst      = id_dst;
    slot0_d.regwrite = id_regwrite;
    slot0_d.memread  = id_memread;
    slot0_d.rs       = id_rs;
    slot0_d.rt       = id_rt;
    slot0_d.rs_used  = id_rs_used;
    slot0_d.rt_used  = id_rt_used;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int i = 1; i < int'(DEPTH); i++) slot_q[i] <= slot_q[i-1];
      slot_q[0] <= slot0_d;
      if (stall_count_clr) begin
        stall_count_q <= '0;
      end else if (stall && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  // The stall must have kept any consumer out of EX until its load result is forwardable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!a_early && !b_early);
    end
  end

endmodule
